maze_cmd_proc: RTL and testbench

//  Consumes 16-bit commands from the UART command receiver (cmd/cmd_rdy/clr_cmd_rdy handshake).

---
 rtl/maze_cmd_proc_if.sv | 33 +++
 rtl/maze_cmd_proc.sv | 115 +++++++++++
 tb/tb_maze_cmd_proc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/maze_cmd_proc_if.sv
// Command/response bundle between the UART command side, the MazeRunner engines
// and the command processor.
//  master : the command processor (consumes cmd, issues starts, emits resp)
//  slave  : the environment (UART wrapper + motion/solve engines)
interface maze_cmd_proc_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        strt_cal;
  logic        cal_done;
  logic        hdng_vld;
  logic [11:0] dsrd_hdng;
  logic        at_hdng;
  logic        strt_mv;
  logic        stop_lft;
  logic        stop_rght;
  logic        mv_cmplt;
  logic        strt_slv;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd, cmd_rdy, cal_done, at_hdng, mv_cmplt,
    output clr_cmd_rdy, strt_cal, hdng_vld, dsrd_hdng, strt_mv,
           stop_lft, stop_rght, strt_slv, send_resp, resp
  );

  modport slave (
    output cmd, cmd_rdy, cal_done, at_hdng, mv_cmplt,
    input  clr_cmd_rdy, strt_cal, hdng_vld, dsrd_hdng, strt_mv,
           stop_lft, stop_rght, strt_slv, send_resp, resp
  );
endinterface

// File: rtl/maze_cmd_proc.sv
// MazeRunner command processor.
// Accepts a 16-bit command ([15:13] opcode, [11:0] operand), starts the matching
// engine (cal / heading / move / solve), waits for its done with a timeout and
// emits a one-byte response (ACK A5, NAK 5A, TMO EE).
// Ports:
//  clk    system clock (posedge)
//  rst_n  synchronous active-low reset
//  bus    maze_cmd_proc_if.master: cmd handshake, engine starts/dones, response
module maze_cmd_proc #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  maze_cmd_proc_if.master bus
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [2:0] OP_CAL  = 3'b000;
  localparam logic [2:0] OP_HDNG = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SLV  = 3'b011;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;
  localparam logic [7:0] TMO = 8'hEE;

  logic [1:0]    state;
  logic [15:0]   cmd_q;
  logic [11:0]   dsrd_hdng;
  logic          stop_lft, stop_rght;
  logic [7:0]    resp;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    op;
  logic          done;
  logic          unused_cmd_bit;

  assign op             = cmd_q[15:13];
  assign unused_cmd_bit = cmd_q[12];

  // Done source follows the opcode latched for this command; other opcodes
  // never reach WAIT.
  always_comb begin
    done = 1'b0;
    case (op)
      OP_CAL:  done = bus.cal_done;
      OP_HDNG: done = bus.at_hdng;
      OP_MOVE: done = bus.mv_cmplt;
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      dsrd_hdng <= '0;
      stop_lft  <= 1'b0;
      stop_rght <= 1'b0;
      resp      <= 8'h00;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_rdy) begin
          cmd_q <= bus.cmd;
          state <= DECODE;
        end
        DECODE: begin
          tmo_cnt <= '0;
          case (op)
            OP_CAL:  state <= WAIT;
            OP_HDNG: begin dsrd_hdng <= cmd_q[11:0]; state <= WAIT; end
            OP_MOVE: begin
              stop_lft  <= cmd_q[1];
              stop_rght <= cmd_q[0];
              state     <= WAIT;
            end
            OP_SLV:  begin resp <= ACK; state <= RESP; end
            default: begin resp <= NAK; state <= RESP; end
          endcase
        end
        WAIT: begin
          // done takes priority over an expiring timeout in the same cycle
          if (done) begin
            resp  <= ACK;
            state <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            resp  <= TMO;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are state decodes, so each fires exactly once per command.
  assign bus.clr_cmd_rdy = (state == IDLE) && bus.cmd_rdy;
  assign bus.strt_cal    = (state == DECODE) && (op == OP_CAL);
  assign bus.hdng_vld    = (state == DECODE) && (op == OP_HDNG);
  assign bus.strt_mv     = (state == DECODE) && (op == OP_MOVE);
  assign bus.strt_slv    = (state == DECODE) && (op == OP_SLV);
  assign bus.send_resp   = (state == RESP);
  assign bus.dsrd_hdng   = dsrd_hdng;
  assign bus.stop_lft    = stop_lft;
  assign bus.stop_rght   = stop_rght;
  assign bus.resp        = resp;
endmodule

// File: tb/tb_maze_cmd_proc.sv
module tb_maze_cmd_proc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_strt_mv = 0;
  int   n_send = 0;

  always #5 clk = ~clk;

  maze_cmd_proc_if bus ();

  maze_cmd_proc #(.TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // pulse tallies sampled away from the active edge
  always @(negedge clk) begin
    if (bus.strt_mv)   n_strt_mv++;
    if (bus.send_resp) n_send++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a command in IDLE, check same-cycle clr, land in DECODE with cmd_rdy dropped
  task automatic issue(input logic [15:0] c);
    bus.cmd     = c;
    bus.cmd_rdy = 1'b1;
    #1;
    chk("clr_same_cycle", bus.clr_cmd_rdy, 1'b1);
    tick();
    bus.cmd_rdy = 1'b0;
    #1;
  endtask

  task automatic chk_no_strt(input string tag);
    chk(tag, {bus.strt_cal, bus.hdng_vld, bus.strt_mv, bus.strt_slv}, 4'b0000);
  endtask

  initial begin
    int k;
    int snap;
    bus.cmd = '0; bus.cmd_rdy = 0; bus.cal_done = 0; bus.at_hdng = 0; bus.mv_cmplt = 0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_resp", bus.resp, 8'h00);
    chk("rst_hdng", bus.dsrd_hdng, 12'h000);
    chk("rst_stops", {bus.stop_lft, bus.stop_rght}, 2'b00);
    chk("rst_pulses", {bus.clr_cmd_rdy, bus.strt_cal, bus.hdng_vld, bus.strt_mv,
                       bus.strt_slv, bus.send_resp}, 6'b0);
    rst_n = 1'b1;
    tick();

    // 1: heading command, done 5 cycles later
    issue(16'h2ABC);
    chk("t1_hdng_vld", bus.hdng_vld, 1'b1);
    chk("t1_clr_gone", bus.clr_cmd_rdy, 1'b0);
    tick();
    chk("t1_dsrd_hdng", bus.dsrd_hdng, 12'hABC);
    chk("t1_vld_pulse", bus.hdng_vld, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t1_no_early_resp", bus.send_resp, 1'b0);
    bus.at_hdng = 1'b1;
    tick();
    bus.at_hdng = 1'b0;
    chk("t1_send_resp", bus.send_resp, 1'b1);
    chk("t1_resp", bus.resp, 8'hA5);
    tick();
    chk("t1_resp_pulse", bus.send_resp, 1'b0);

    // 2: move stopping left
    snap = n_strt_mv;
    issue(16'h4002);
    chk("t2_strt_mv", bus.strt_mv, 1'b1);
    tick();
    chk("t2_stops", {bus.stop_lft, bus.stop_rght}, 2'b10);
    tick(); tick();
    bus.mv_cmplt = 1'b1;
    tick();
    bus.mv_cmplt = 1'b0;
    chk("t2_send_resp", bus.send_resp, 1'b1);
    chk("t2_resp", bus.resp, 8'hA5);
    tick(); tick();
    chk("t2_one_strt_mv", n_strt_mv - snap, 1);
    chk("t2_hdng_held", bus.dsrd_hdng, 12'hABC);

    // 3: calibration that never completes
    issue(16'h0000);
    chk("t3_strt_cal", bus.strt_cal, 1'b1);
    k = 0;
    while (!bus.send_resp && k < 40) begin
      tick();
      k++;
    end
    chk("t3_tmo_latency", k, 17);
    chk("t3_resp_tmo", bus.resp, 8'hEE);
    tick();

    // 4: illegal opcode, then solve
    issue(16'hE123);
    chk_no_strt("t4_nak_no_strt");
    tick();
    chk("t4_nak_send", bus.send_resp, 1'b1);
    chk("t4_nak_resp", bus.resp, 8'h5A);
    tick();
    issue(16'h6000);
    chk("t4_strt_slv", bus.strt_slv, 1'b1);
    tick();
    chk("t4_slv_send", bus.send_resp, 1'b1);
    chk("t4_slv_resp", bus.resp, 8'hA5);
    tick();

    // 5: cmd_rdy held while busy is not cleared until back in IDLE
    issue(16'h2123);
    bus.cmd     = 16'h4001;
    bus.cmd_rdy = 1'b1;
    #1;
    chk("t5_no_clr_decode", bus.clr_cmd_rdy, 1'b0);
    tick();
    chk("t5_no_clr_wait", bus.clr_cmd_rdy, 1'b0);
    bus.at_hdng = 1'b1;
    tick();
    bus.at_hdng = 1'b0;
    chk("t5_resp_send", bus.send_resp, 1'b1);
    chk("t5_no_clr_resp", bus.clr_cmd_rdy, 1'b0);
    tick();
    chk("t5_clr_idle", bus.clr_cmd_rdy, 1'b1);
    tick();
    bus.cmd_rdy = 1'b0;
    chk("t5_second_strt_mv", bus.strt_mv, 1'b1);
    tick();
    chk("t5_stops", {bus.stop_lft, bus.stop_rght}, 2'b01);
    chk("t5_hdng", bus.dsrd_hdng, 12'h123);
    bus.mv_cmplt = 1'b1;
    tick();
    bus.mv_cmplt = 1'b0;
    chk("t5_mv_resp", bus.resp, 8'hA5);
    tick();

    // 6a: reset in the middle of WAIT
    issue(16'h0000);
    tick(); tick(); tick();
    snap = n_send;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_hdng", bus.dsrd_hdng, 12'h000);
    chk("t6_rst_stops", {bus.stop_lft, bus.stop_rght}, 2'b00);
    chk("t6_rst_resp", bus.resp, 8'h00);
    chk("t6_rst_send", bus.send_resp, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_no_resp_after_rst", n_send - snap, 0);

    // 6b: done arrives on the last WAIT cycle before timeout
    issue(16'h2000);
    for (int i = 0; i < 16; i++) tick();
    chk("t6_no_tmo_yet", bus.send_resp, 1'b0);
    bus.at_hdng = 1'b1;
    tick();
    bus.at_hdng = 1'b0;
    chk("t6_boundary_send", bus.send_resp, 1'b1);
    chk("t6_boundary_ack", bus.resp, 8'hA5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
